ts_null_stuffer: RTL and testbench
==================================

TS_NULL_STUFFER -- requirements
Module: ts_null_stuffer

Interface
REQ-001 SHALL have parameter DEPTH_PKTS, default 4, packet slots in buffer (power of 2, 2..16).
REQ-002 SHALL have port CLK  in  1  sole clock; every flop is posedge CLK.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port TS_DATA  in  8  TS byte from the SPI TS receiver.
REQ-005 SHALL have port TS_DATA_VALID  in  1  TS_DATA qualifier, one byte per asserted cycle.
REQ-006 SHALL have port OUT_READY  in  1  downstream modulator accepts a byte this cycle.
REQ-007 SHALL have port OUT_DATA  out  8  CBR TS byte.
REQ-008 SHALL have port OUT_VALID  out  1  OUT_DATA qualifier.
REQ-009 SHALL have port OUT_SOP  out  1  high on byte 0 of each output packet.
REQ-010 SHALL have port OUT_NULL  out  1  high on every byte of an inserted null packet.
REQ-011 SHALL have port OVERFLOW_COUNT  out  8  dropped input packets, saturating at 255.
REQ-012 SHALL have port NULL_PKT_COUNT  out  16  inserted null packets, wrapping.
REQ-013 SHALL have port SYNC_LOST  out  1  input aligner in HUNT.
REQ-014 SHALL have port RESET_COUNTS  in  1  one-cycle pulse clearing both counters next cycle.

Function
REQ-015 Input aligner SHALL have states HUNT and LOCK; HUNT->LOCK on a valid byte equal to 0x47, that byte becoming byte 0 of a packet.
REQ-016 In LOCK, the aligner SHALL count valid bytes 0..187 and write them to the current write slot.
REQ-017 A valid byte at index 0 not equal to 0x47 SHALL send the aligner to HUNT, with the partial packet discarded and no commit.
REQ-018 On writing byte 187, the slot SHALL be committed (write slot pointer +1 mod DEPTH_PKTS, packet count +1), and the aligner SHALL remain in LOCK expecting 0x47.
REQ-019 If no free slot exists when byte 0 arrives, that whole 188-byte packet SHALL be dropped (bytes counted but not written) and OVERFLOW_COUNT incremented once.
REQ-020 Output SHALL use a valid/ready handshake: a byte transfers when OUT_VALID && OUT_READY; OUT_DATA/OUT_SOP/OUT_NULL SHALL hold stable while OUT_VALID && !OUT_READY.
REQ-021 OUT_VALID SHALL be 1 on every cycle from the second cycle after RST deasserts, giving a constant-bitrate stream.
REQ-022 At each output packet boundary, a stored packet SHALL be chosen if the packet count, registered as of the previous cycle, is nonzero; otherwise a null packet SHALL be chosen.
REQ-023 A null packet SHALL be 0x47, 0x1F, 0xFF, 0x10, then 184 bytes of 0xFF; NULL_PKT_COUNT SHALL increment on transfer of its byte 0.
REQ-024 A stored packet SHALL free its slot (read pointer +1, count -1) on transfer of its byte 187.
REQ-025 A commit and a free in the same cycle SHALL leave the count unchanged; the count SHALL never exceed DEPTH_PKTS.
REQ-026 Latency: the first byte of a committed packet SHALL appear no earlier than 2 cycles after commit, at the next output packet boundary.
REQ-027 Buffer RAM read latency SHALL be 1 cycle, hidden by a one-byte prefetch so back-to-back transfers at OUT_READY=1 have no bubbles.
REQ-028 RESET_COUNTS SHALL take priority over a same-cycle counter increment.

Reset
REQ-029 On RST: aligner SHALL be in HUNT, pointers/count 0, OUT_VALID=0, OUT_SOP=0, OUT_NULL=0, OUT_DATA=0x00, counters 0, and SYNC_LOST=1.
REQ-030 RST mid-packet SHALL abort both input and output packets; RAM contents need not be cleared.

Structure
REQ-031 Shared package ts_pkg SHALL hold TS_PKT_LEN=188, TS_SYNC_BYTE=0x47, the null header bytes, and the aligner state encoding.
REQ-032 Buffer SHALL be one sub-module ts_pkt_ram: simple dual-port, DEPTH_PKTS*188 x 8, sync write, sync read.

Verification
REQ-033 Idle input, OUT_READY=1 -> continuous null packets; NULL_PKT_COUNT=3 after 564 transfers; OUT_SOP every 188 bytes.
REQ-034 Two valid packets (0x47, PID 0x0100, payload ramp) -> emitted byte-exact at the next boundaries, OUT_NULL=0, then nulls resume.
REQ-035 Six packets with OUT_READY=0 throughout, DEPTH_PKTS=4 -> OVERFLOW_COUNT=2; the four stored packets emitted in order once ready.
REQ-036 Garbage 0x00 x50 then aligned packets -> SYNC_LOST=1 until the first 0x47, then 0; a bad sync at byte 188 -> HUNT, packet not emitted.
REQ-037 OUT_READY toggling every cycle -> OUT_DATA held stable on stalls; no byte lost or duplicated.
REQ-038 RST pulse at input byte 100 and output byte 50 -> all outputs at reset values; clean null stream restarts.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared constants and types for the TS null-stuffer: packet geometry, null
// packet header, aligner state encoding and the output beat payload.
package ts_pkg;

  localparam int unsigned TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_LAST_IDX  = 8'd187;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  // Null packet: sync, PID 0x1FFF with flags clear, payload-only AFC, 0xFF fill
  localparam logic [7:0]  TS_NULL_HDR1 = 8'h1F;
  localparam logic [7:0]  TS_NULL_HDR2 = 8'hFF;
  localparam logic [7:0]  TS_NULL_HDR3 = 8'h10;
  localparam logic [7:0]  TS_NULL_FILL = 8'hFF;

  typedef enum logic {
    ALIGN_HUNT = 1'b0,
    ALIGN_LOCK = 1'b1
  } align_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       is_null;
  } ts_beat_t;

  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = TS_SYNC_BYTE;
      8'd1:    b = TS_NULL_HDR1;
      8'd2:    b = TS_NULL_HDR2;
      8'd3:    b = TS_NULL_HDR3;
      default: b = TS_NULL_FILL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_pkt_ram.sv
// Packet buffer: simple dual-port RAM, one write and one read port, both
// synchronous; the read data register holds while i_re is low.
module ts_pkt_ram
  import ts_pkg::*;
#(
  parameter int unsigned DEPTH_PKTS = 4,
  parameter int unsigned AW         = $clog2(DEPTH_PKTS * TS_PKT_LEN)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  localparam int unsigned WORDS = DEPTH_PKTS * TS_PKT_LEN;

  logic [7:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/ts_null_stuffer.sv
// Aligns an SPI TS byte stream into a packet buffer and emits a constant-rate
// TS stream, filling gaps with null packets at packet boundaries.
module ts_null_stuffer
  import ts_pkg::*;
#(
  parameter int unsigned DEPTH_PKTS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  TS_DATA,
  input  logic        TS_DATA_VALID,
  input  logic        OUT_READY,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  output logic        OUT_SOP,
  output logic        OUT_NULL,
  output logic [7:0]  OVERFLOW_COUNT,
  output logic [15:0] NULL_PKT_COUNT,
  output logic        SYNC_LOST,
  input  logic        RESET_COUNTS
);

  localparam int unsigned SW = $clog2(DEPTH_PKTS);
  localparam int unsigned CW = SW + 1;
  localparam int unsigned AW = $clog2(DEPTH_PKTS * TS_PKT_LEN);

  function automatic logic [AW-1:0] slot_base(input logic [SW-1:0] slot);
    return AW'(slot) * AW'(TS_PKT_LEN);
  endfunction

  // Input aligner state
  align_state_t   r_state;
  align_state_t   w_state_nxt;
  logic [7:0]     r_in_idx;
  logic [7:0]     w_in_idx_nxt;
  logic           r_drop;
  logic           w_drop_nxt;
  logic           r_sync_lost;
  logic [SW-1:0]  r_wr_slot;
  logic           w_we;
  logic           w_commit;
  logic           w_ovf;
  logic           w_full;
  logic [AW-1:0]  w_waddr;

  // Shared occupancy
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_cnt_d;

  // Output side
  ts_beat_t       r_beat;
  ts_beat_t       w_beat_nxt;
  logic           r_out_valid;
  logic [7:0]     r_out_idx;
  logic [7:0]     w_out_idx_nxt;
  logic [SW-1:0]  r_rd_slot;
  logic [SW-1:0]  w_rd_slot_nxt;
  logic           w_xfer;
  logic           w_load;
  logic           w_free;
  logic           w_avail;
  logic           w_re;
  logic [AW-1:0]  w_raddr;
  logic [7:0]     w_rdata;

  logic [7:0]     r_ovf_cnt;
  logic [15:0]    r_null_cnt;

  assign w_full  = (r_count == CW'(DEPTH_PKTS));
  assign w_waddr = slot_base(r_wr_slot) + AW'(r_in_idx);

  // Aligner next-state: byte 0 must be the sync byte; a full buffer at byte 0
  // marks the whole packet for dropping.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_idx_nxt = r_in_idx;
    w_drop_nxt   = r_drop;
    w_we         = 1'b0;
    w_commit     = 1'b0;
    w_ovf        = 1'b0;
    if (TS_DATA_VALID) begin
      if (r_state == ALIGN_HUNT || r_in_idx == 8'd0) begin
        if (TS_DATA == TS_SYNC_BYTE) begin
          w_state_nxt  = ALIGN_LOCK;
          w_in_idx_nxt = 8'd1;
          w_drop_nxt   = w_full;
          w_we         = !w_full;
          w_ovf        = w_full;
        end else begin
          w_state_nxt  = ALIGN_HUNT;
          w_in_idx_nxt = 8'd0;
          w_drop_nxt   = 1'b0;
        end
      end else begin
        w_we = !r_drop;
        if (r_in_idx == TS_LAST_IDX) begin
          w_in_idx_nxt = 8'd0;
          w_commit     = !r_drop;
        end else begin
          w_in_idx_nxt = r_in_idx + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ALIGN_HUNT;
      r_in_idx    <= 8'd0;
      r_drop      <= 1'b0;
      r_sync_lost <= 1'b1;
      r_wr_slot   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_idx    <= w_in_idx_nxt;
      r_drop      <= w_drop_nxt;
      r_sync_lost <= (w_state_nxt == ALIGN_HUNT);
      if (w_commit) begin
        r_wr_slot <= r_wr_slot + SW'(1);
      end
    end
  end

  ts_pkt_ram #(
    .DEPTH_PKTS (DEPTH_PKTS),
    .AW         (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (TS_DATA),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_xfer        = r_out_valid && OUT_READY;
  assign w_load        = !r_out_valid || OUT_READY;
  assign w_free        = w_xfer && !r_beat.is_null && (r_out_idx == TS_LAST_IDX);
  assign w_rd_slot_nxt = w_free ? r_rd_slot + SW'(1) : r_rd_slot;
  // The delayed count still includes a packet freed this cycle, so discount it
  assign w_avail       = ((r_cnt_d - CW'(w_free)) != '0);

  // Output next-beat: stored packets always start with the sync byte, so byte 0
  // is sourced locally while the RAM prefetches byte 1.
  always_comb begin
    w_beat_nxt    = r_beat;
    w_out_idx_nxt = r_out_idx;
    w_re          = 1'b0;
    w_raddr       = '0;
    if (w_load) begin
      if (!r_out_valid || r_out_idx == TS_LAST_IDX) begin
        w_out_idx_nxt = 8'd0;
        w_beat_nxt    = '{data: TS_SYNC_BYTE, sop: 1'b1, is_null: !w_avail};
        w_re          = w_avail;
        w_raddr       = slot_base(w_rd_slot_nxt) + AW'(1);
      end else begin
        w_out_idx_nxt   = r_out_idx + 8'd1;
        w_beat_nxt.sop  = 1'b0;
        w_beat_nxt.data = r_beat.is_null ? null_byte(w_out_idx_nxt) : w_rdata;
        w_re            = !r_beat.is_null && (w_out_idx_nxt != TS_LAST_IDX);
        w_raddr         = slot_base(r_rd_slot) + AW'(w_out_idx_nxt) + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= 8'd0;
      r_rd_slot   <= '0;
    end else begin
      r_beat      <= w_beat_nxt;
      r_out_valid <= 1'b1;
      r_out_idx   <= w_out_idx_nxt;
      r_rd_slot   <= w_rd_slot_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
      r_cnt_d <= '0;
    end else begin
      r_cnt_d <= r_count;
      case ({w_commit, w_free})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Statistics counters; a clear request wins over an increment
  always_ff @(posedge CLK) begin
    if (RST || RESET_COUNTS) begin
      r_ovf_cnt  <= 8'd0;
      r_null_cnt <= 16'd0;
    end else begin
      if (w_ovf && r_ovf_cnt != 8'hFF) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
      if (w_xfer && r_beat.is_null && r_out_idx == 8'd0) begin
        r_null_cnt <= r_null_cnt + 16'd1;
      end
    end
  end

  assign OUT_DATA       = r_beat.data;
  assign OUT_SOP        = r_beat.sop;
  assign OUT_NULL       = r_beat.is_null;
  assign OUT_VALID      = r_out_valid;
  assign OVERFLOW_COUNT = r_ovf_cnt;
  assign NULL_PKT_COUNT = r_null_cnt;
  assign SYNC_LOST      = r_sync_lost;

endmodule

// File: tb/tb_ts_null_stuffer.sv
// Directed self-checking bench for ts_null_stuffer: null fill, stored packet
// pass-through, overflow, sync loss, back-pressure and mid-packet reset.
module tb_ts_null_stuffer;

  logic        CLK;
  logic        RST;
  logic [7:0]  TS_DATA;
  logic        TS_DATA_VALID;
  logic        OUT_READY;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_SOP;
  logic        OUT_NULL;
  logic [7:0]  OVERFLOW_COUNT;
  logic [15:0] NULL_PKT_COUNT;
  logic        SYNC_LOST;
  logic        RESET_COUNTS;

  ts_null_stuffer #(.DEPTH_PKTS(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .TS_DATA        (TS_DATA),
    .TS_DATA_VALID  (TS_DATA_VALID),
    .OUT_READY      (OUT_READY),
    .OUT_DATA       (OUT_DATA),
    .OUT_VALID      (OUT_VALID),
    .OUT_SOP        (OUT_SOP),
    .OUT_NULL       (OUT_NULL),
    .OVERFLOW_COUNT (OVERFLOW_COUNT),
    .NULL_PKT_COUNT (NULL_PKT_COUNT),
    .SYNC_LOST      (SYNC_LOST),
    .RESET_COUNTS   (RESET_COUNTS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         n_vec;
  int         n_err;
  int         cyc_n;
  logic [7:0] q_data[$];
  logic       q_sop[$];
  logic       q_null[$];
  int         exp_ids[$];
  logic       p_stall;
  logic [9:0] p_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet k: sync, PID 0x0100, CC=k, payload ramp kept free of 0x47 so that
  // discarded bytes can never re-lock the aligner mid-payload.
  function automatic logic [7:0] pkt_byte(input int k, input int i);
    logic [7:0] b;
    case (i)
      0:       b = 8'h47;
      1:       b = 8'h01;
      2:       b = 8'h00;
      3:       b = 8'h10 | {4'h0, 4'(k)};
      default: begin
        b = 8'(i + k * 7);
        if (b == 8'h47) b = 8'h48;
      end
    endcase
    return b;
  endfunction

  function automatic logic [7:0] nb(input int i);
    logic [7:0] b;
    case (i)
      0:       b = 8'h47;
      1:       b = 8'h1F;
      3:       b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  function automatic logic rdy_of(input int m);
    return (m == 2) ? logic'(cyc_n[0]) : (m != 0);
  endfunction

  // One clock: drive inputs, check stall hold, log a transfer, advance
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
    TS_DATA_VALID = v;
    TS_DATA       = d;
    OUT_READY     = rdy;
    if (p_stall) chk("stall_hold", {22'd0, OUT_DATA, OUT_SOP, OUT_NULL}, {22'd0, p_beat});
    if (OUT_VALID && rdy) begin
      q_data.push_back(OUT_DATA);
      q_sop.push_back(OUT_SOP);
      q_null.push_back(OUT_NULL);
    end
    p_stall = OUT_VALID && !rdy && !RST;
    p_beat  = {OUT_DATA, OUT_SOP, OUT_NULL};
    cyc_n++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input int m);
    for (int t = 0; t < n; t++) cyc(1'b0, 8'h00, rdy_of(m));
  endtask

  task automatic send_range(input int k, input int lo, input int hi, input int m);
    for (int i = lo; i <= hi; i++) cyc(1'b1, pkt_byte(k, i), rdy_of(m));
  endtask

  task automatic release_rst();
    RST = 1'b0;
    q_data.delete();
    q_sop.delete();
    q_null.delete();
    exp_ids.delete();
    p_stall = 1'b0;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_valid"}, 32'(OUT_VALID), 0);
    chk({t, "_sop"}, 32'(OUT_SOP), 0);
    chk({t, "_null"}, 32'(OUT_NULL), 0);
    chk({t, "_data"}, 32'(OUT_DATA), 0);
    chk({t, "_sync_lost"}, 32'(SYNC_LOST), 1);
    chk({t, "_ovf_cnt"}, 32'(OVERFLOW_COUNT), 0);
    chk({t, "_null_cnt"}, 32'(NULL_PKT_COUNT), 0);
  endtask

  // Split the logged stream into 188-byte packets; nulls must match the null
  // pattern, stored packets must match exp_ids in order.
  task automatic check_stream(input string tag);
    int   n_chunks;
    int   p;
    int   base;
    logic is_null;
    logic [7:0] e;
    n_chunks = q_data.size() / 188;
    p = 0;
    for (int c = 0; c < n_chunks; c++) begin
      base    = c * 188;
      is_null = q_null[base];
      for (int i = 0; i < 188; i++) begin
        chk({tag, "_sop"}, 32'(q_sop[base + i]), 32'(i == 0));
        chk({tag, "_nullflag"}, 32'(q_null[base + i]), 32'(is_null));
        if (is_null) begin
          chk({tag, "_nulldata"}, 32'(q_data[base + i]), 32'(nb(i)));
        end else if (p < exp_ids.size()) begin
          e = pkt_byte(exp_ids[p], i);
          chk({tag, "_pktdata"}, 32'(q_data[base + i]), 32'(e));
        end
      end
      if (!is_null) p++;
    end
    chk({tag, "_npkts"}, p, exp_ids.size());
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc_n = 0; p_stall = 1'b0; p_beat = '0;
    RST = 1'b1; TS_DATA = 8'h00; TS_DATA_VALID = 1'b0; OUT_READY = 1'b1;
    RESET_COUNTS = 1'b0;
    @(posedge CLK);
    #1;

    // Reset state
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk_reset("rst");
    release_rst();
    cyc(1'b0, 8'h00, 1'b1);
    chk("valid_after_rst", 32'(OUT_VALID), 1);

    // Idle input: continuous null packets
    for (int t = 0; t < 700 && q_data.size() < 564; t++) cyc(1'b0, 8'h00, 1'b1);
    chk("idle_xfers", q_data.size(), 564);
    chk("idle_null_cnt", 32'(NULL_PKT_COUNT), 3);
    chk("idle_sync_lost", 32'(SYNC_LOST), 1);
    check_stream("idle");

    // Counter clear on the very cycle a null byte 0 transfers
    for (int t = 0; t < 400 && !OUT_SOP; t++) cyc(1'b0, 8'h00, 1'b1);
    chk("rc_at_sop", 32'(OUT_SOP && OUT_NULL), 1);
    RESET_COUNTS = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    RESET_COUNTS = 1'b0;
    chk("rc_priority", 32'(NULL_PKT_COUNT), 0);
    for (int t = 0; t < 400 && !OUT_SOP; t++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rc_then_count", 32'(NULL_PKT_COUNT), 1);

    // Two packets pass through byte-exact, then nulls resume
    RST = 1'b1; cyc(1'b0, 8'h00, 1'b1); release_rst();
    idle(20, 1);
    send_range(0, 0, 187, 1);
    send_range(1, 0, 187, 1);
    idle(600, 1);
    exp_ids = '{0, 1};
    check_stream("two_pkts");
    chk("two_pkts_tail_null", 32'(q_null[(q_data.size() / 188 - 1) * 188]), 1);
    chk("two_pkts_ovf", 32'(OVERFLOW_COUNT), 0);

    // Six packets into a stalled output: two dropped, four kept in order
    RST = 1'b1; cyc(1'b0, 8'h00, 1'b1); release_rst();
    for (int k = 0; k < 6; k++) send_range(k, 0, 187, 0);
    chk("ovf_count", 32'(OVERFLOW_COUNT), 2);
    chk("ovf_no_xfer", q_data.size(), 0);
    chk("ovf_held_data", 32'(OUT_DATA), 32'h47);
    chk("ovf_held_null", 32'(OUT_NULL), 1);
    chk("ovf_null_cnt", 32'(NULL_PKT_COUNT), 0);
    idle(188 * 6, 1);
    exp_ids = '{0, 1, 2, 3};
    check_stream("ovf");
    RESET_COUNTS = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    RESET_COUNTS = 1'b0;
    chk("ovf_cleared", 32'(OVERFLOW_COUNT), 0);

    // Garbage, lock, then a bad sync drops the following packet
    RST = 1'b1; cyc(1'b0, 8'h00, 1'b1); release_rst();
    for (int t = 0; t < 50; t++) cyc(1'b1, 8'h00, 1'b1);
    chk("garbage_sync_lost", 32'(SYNC_LOST), 1);
    send_range(0, 0, 0, 1);
    chk("locked_sync_lost", 32'(SYNC_LOST), 0);
    send_range(0, 1, 187, 1);
    chk("still_locked", 32'(SYNC_LOST), 0);
    cyc(1'b1, 8'h46, 1'b1);
    chk("bad_sync_lost", 32'(SYNC_LOST), 1);
    send_range(1, 1, 187, 1);
    idle(10, 1);
    send_range(2, 0, 187, 1);
    idle(800, 1);
    exp_ids = '{0, 2};
    check_stream("sync");

    // OUT_READY toggling every cycle
    RST = 1'b1; cyc(1'b0, 8'h00, 1'b1); release_rst();
    for (int k = 0; k < 3; k++) send_range(k, 0, 187, 2);
    idle(2400, 2);
    exp_ids = '{0, 1, 2};
    check_stream("toggle");
    chk("toggle_ovf", 32'(OVERFLOW_COUNT), 0);

    // Reset at input byte 100 / output byte 50 aborts both packets
    RST = 1'b1; cyc(1'b0, 8'h00, 1'b1); release_rst();
    idle(138, 1);
    send_range(0, 0, 99, 1);
    chk("mid_locked", 32'(SYNC_LOST), 0);
    RST = 1'b1;
    send_range(0, 100, 100, 1);
    chk_reset("mid_rst");
    release_rst();
    send_range(0, 101, 187, 1);
    idle(400, 1);
    check_stream("post_rst");
    chk("post_rst_sync_lost", 32'(SYNC_LOST), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
